snake_body: RTL and testbench

SNAKE_BODY -- requirements
Module: snake_body

---
 rtl/snake_pkg.sv | 29 ++
 rtl/snake_seg_match.sv | 23 ++
 rtl/snake_body.sv | 148 ++++++++++++++
 tb/tb_snake_body.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake constants: grid geometry (also used by the prey generator),
// direction encoding and the body FSM state encoding.
package snake_pkg;

  localparam int GRID_H_WIDTH = 5;
  localparam int GRID_V_WIDTH = 5;
  localparam int GRID_H_MAX   = 31;
  localparam int GRID_V_MAX   = 23;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SCAN = 2'd1,
    ST_MOVE = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  // Opposite directions differ only in bit 1 with this encoding.
  function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_seg_match.sv
// Parallel compare of one grid cell against every live body segment.
module snake_seg_match #(
  parameter int H_LOGIC_WIDTH = 5,
  parameter int V_LOGIC_WIDTH = 5,
  parameter int MAX_LEN       = 16,
  parameter int LEN_W         = 5
) (
  input  logic [MAX_LEN-1:0][H_LOGIC_WIDTH-1:0] seg_x,
  input  logic [MAX_LEN-1:0][V_LOGIC_WIDTH-1:0] seg_y,
  input  logic [LEN_W-1:0]                      len,
  input  logic [H_LOGIC_WIDTH-1:0]              qx,
  input  logic [V_LOGIC_WIDTH-1:0]              qy,
  output logic                                  hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(len)) && (seg_x[i] == qx) && (seg_y[i] == qy)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/snake_body.sv
// Snake body: segment registers, move/collision FSM and renderer occupancy query.
// State table: RUN wait tick | SCAN serial self-hit check | MOVE shift body | DEAD frozen until rst
module snake_body
  import snake_pkg::*;
#(
  parameter int H_LOGIC_WIDTH = GRID_H_WIDTH,
  parameter int V_LOGIC_WIDTH = GRID_V_WIDTH,
  parameter int H_LOGIC_MAX   = GRID_H_MAX,
  parameter int V_LOGIC_MAX   = GRID_V_MAX,
  parameter int MAX_LEN       = 16,
  parameter int LEN_W         = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [1:0]               dir_in,
  input  logic                     dir_vld,
  input  logic [H_LOGIC_WIDTH-1:0] preyx,
  input  logic [V_LOGIC_WIDTH-1:0] preyy,
  input  logic                     prey_vld,
  output logic                     eat,
  output logic [H_LOGIC_WIDTH-1:0] headx,
  output logic [V_LOGIC_WIDTH-1:0] heady,
  output logic [LEN_W-1:0]         len,
  output logic                     game_over,
  input  logic [H_LOGIC_WIDTH-1:0] qx,
  input  logic [V_LOGIC_WIDTH-1:0] qy,
  output logic                     q_hit
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [H_LOGIC_WIDTH-1:0] H_MAX = H_LOGIC_WIDTH'(H_LOGIC_MAX);
  localparam logic [V_LOGIC_WIDTH-1:0] V_MAX = V_LOGIC_WIDTH'(V_LOGIC_MAX);

  logic [MAX_LEN-1:0][H_LOGIC_WIDTH-1:0] seg_x;
  logic [MAX_LEN-1:0][V_LOGIC_WIDTH-1:0] seg_y;
  logic [LEN_W-1:0]         len_r;
  logic [IDX_W-1:0]         scan_idx;
  logic [H_LOGIC_WIDTH-1:0] nxt_x, calc_x;
  logic [V_LOGIC_WIDTH-1:0] nxt_y, calc_y;
  logic                     wall, calc_wall;
  logic                     scan_hit, scan_last, prey_hit, q_hit_c;
  state_t                   state;
  dir_t                     dir_r;

  always_comb begin
    calc_x    = seg_x[0];
    calc_y    = seg_y[0];
    calc_wall = 1'b0;
    case (dir_r)
      DIR_UP:    begin calc_wall = (seg_y[0] == '0);    calc_y = seg_y[0] - V_LOGIC_WIDTH'(1); end
      DIR_RIGHT: begin calc_wall = (seg_x[0] == H_MAX); calc_x = seg_x[0] + H_LOGIC_WIDTH'(1); end
      DIR_DOWN:  begin calc_wall = (seg_y[0] == V_MAX); calc_y = seg_y[0] + V_LOGIC_WIDTH'(1); end
      DIR_LEFT:  begin calc_wall = (seg_x[0] == '0);    calc_x = seg_x[0] - H_LOGIC_WIDTH'(1); end
      default: ;
    endcase
  end

  // One comparator walks the body; the tail is never visited since it vacates.
  assign scan_hit  = wall || ((seg_x[scan_idx] == nxt_x) && (seg_y[scan_idx] == nxt_y));
  assign scan_last = (LEN_W'(scan_idx) == (len_r - LEN_W'(2)));
  assign prey_hit  = prey_vld && (nxt_x == preyx) && (nxt_y == preyy);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      seg_x[0]  <= H_LOGIC_WIDTH'(4);
      seg_x[1]  <= H_LOGIC_WIDTH'(3);
      seg_x[2]  <= H_LOGIC_WIDTH'(2);
      seg_y[0]  <= V_LOGIC_WIDTH'(4);
      seg_y[1]  <= V_LOGIC_WIDTH'(4);
      seg_y[2]  <= V_LOGIC_WIDTH'(4);
      len_r     <= LEN_W'(3);
      dir_r     <= DIR_RIGHT;
      state     <= ST_RUN;
      scan_idx  <= '0;
      nxt_x     <= '0;
      nxt_y     <= '0;
      wall      <= 1'b0;
      eat       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      if (dir_vld && (state != ST_DEAD) && !is_opposite(dir_in, dir_r))
        dir_r <= dir_t'(dir_in);
      case (state)
        ST_RUN: begin
          if (tick) begin
            nxt_x    <= calc_x;
            nxt_y    <= calc_y;
            wall     <= calc_wall;
            scan_idx <= '0;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_hit) begin
            state     <= ST_DEAD;
            game_over <= 1'b1;
          end else if (scan_last) begin
            eat   <= prey_hit;
            state <= ST_MOVE;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        ST_MOVE: begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nxt_x;
          seg_y[0] <= nxt_y;
          if (eat && (len_r != LEN_W'(MAX_LEN))) len_r <= len_r + LEN_W'(1);
          eat   <= 1'b0;
          state <= ST_RUN;
        end
        default: ;
      endcase
    end
  end

  snake_seg_match #(
    .H_LOGIC_WIDTH(H_LOGIC_WIDTH),
    .V_LOGIC_WIDTH(V_LOGIC_WIDTH),
    .MAX_LEN      (MAX_LEN),
    .LEN_W        (LEN_W)
  ) u_q_match (
    .seg_x(seg_x),
    .seg_y(seg_y),
    .len  (len_r),
    .qx   (qx),
    .qy   (qy),
    .hit  (q_hit_c)
  );

  always_ff @(posedge clk) begin
    if (rst) q_hit <= 1'b0;
    else     q_hit <= q_hit_c;
  end

  assign headx = seg_x[0];
  assign heady = seg_y[0];
  assign len   = len_r;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: a queue-based body model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_snake_body;

  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, dir_vld = 1'b0, prey_vld = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic [4:0] preyx = '0, preyy = '0, qx = '0, qy = '0;
  logic [4:0] headx, heady, len;
  logic       eat, game_over, q_hit;

  always #5 clk = ~clk;

  snake_body dut (
    .clk(clk), .rst(rst), .tick(tick), .dir_in(dir_in), .dir_vld(dir_vld),
    .preyx(preyx), .preyy(preyy), .prey_vld(prey_vld), .eat(eat),
    .headx(headx), .heady(heady), .len(len), .game_over(game_over),
    .qx(qx), .qy(qy), .q_hit(q_hit)
  );

  int n_chk = 0, n_pass = 0;
  int bx[$], by[$];
  int m_dir;
  bit m_dead, m_eat, chk_en = 1'b0, q_exp = 1'b0;
  int ec;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit occ(input int x, input int y);
    foreach (bx[i]) if (bx[i] == x && by[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    bx = '{4, 3, 2};
    by = '{4, 4, 4};
    m_dir  = 1;
    m_dead = 1'b0;
    m_eat  = 1'b0;
  endtask

  // Occupancy seen by the DUT at each edge (model only changes #1 after edges).
  always @(posedge clk) q_exp = rst ? 1'b0 : occ(qx, qy);

  always @(negedge clk) begin
    if (chk_en) begin
      check("headx", headx, bx[0]);
      check("heady", heady, by[0]);
      check("len", len, bx.size());
      check("game_over", game_over, m_dead);
      check("eat", eat, m_eat);
      check("q_hit", q_hit, q_exp);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_dir(input int d);
    dir_in = 2'(d); dir_vld = 1'b1;
    @(posedge clk); #1;
    dir_vld = 1'b0;
    if (!m_dead && ((d ^ m_dir) != 2)) m_dir = d;
  endtask

  // One move request held for 'hold' cycles; extra cycles land in SCAN and must be dropped.
  task automatic do_tick(input int hold, output int eat_cnt);
    int nx, ny, mlen, hitk, death_j, last;
    bit wall, was_dead;
    was_dead = m_dead;
    mlen = bx.size();
    nx = bx[0]; ny = by[0]; wall = 1'b0;
    case (m_dir)
      0: begin wall = (by[0] == 0);  ny = by[0] - 1; end
      1: begin wall = (bx[0] == 31); nx = bx[0] + 1; end
      2: begin wall = (by[0] == 23); ny = by[0] + 1; end
      default: begin wall = (bx[0] == 0); nx = bx[0] - 1; end
    endcase
    hitk = -1;
    for (int i = 0; i < mlen - 1; i++) if (hitk < 0 && bx[i] == nx && by[i] == ny) hitk = i;
    death_j = wall ? 1 : (hitk >= 0 ? hitk + 1 : 0);
    last = was_dead ? 0 : (death_j > 0 ? death_j : mlen);
    if (hold - 1 > last) last = hold - 1;
    eat_cnt = 0;
    tick = 1'b1;
    for (int j = 0; j <= last; j++) begin
      @(posedge clk); #1;
      if (j == hold - 1) tick = 1'b0;
      if (!was_dead) begin
        if (death_j > 0 && j == death_j) m_dead = 1'b1;
        if (death_j == 0 && j == mlen - 1)
          m_eat = prey_vld && (nx == int'(preyx)) && (ny == int'(preyy));
        if (death_j == 0 && j == mlen) begin
          bx.push_front(nx); by.push_front(ny);
          if (!m_eat || bx.size() > 16) begin void'(bx.pop_back()); void'(by.pop_back()); end
          m_eat = 1'b0;
        end
      end
      if (eat) eat_cnt++;
    end
    tick = 1'b0;
  endtask

  task automatic q_probe(input string name, input int x, input int y, input int exp);
    qx = 5'(x); qy = 5'(y);
    @(posedge clk); #1;
    check(name, q_hit, exp);
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_headx", headx, 4);
    check("rst_len", len, 3);
    check("rst_q_hit", q_hit, 0);

    q_probe("q_body_3_4", 3, 4, 1);
    q_probe("q_empty_9_9", 9, 9, 0);

    // Move right with far prey; tick held two cycles must yield a single move.
    preyx = 5'd10; preyy = 5'd10; prey_vld = 1'b1;
    do_tick(2, ec);
    check("mv_headx", headx, 5);
    check("mv_heady", heady, 4);
    check("mv_len", len, 3);
    check("mv_eat_cnt", ec, 0);
    check("model_seg2x", bx[2], 3);
    q_probe("q_tail_vacated", 2, 4, 0);

    // Eat prey directly ahead.
    do_reset();
    preyx = 5'd5; preyy = 5'd4; prey_vld = 1'b1;
    do_tick(1, ec);
    check("eat_cnt", ec, 1);
    check("eat_len", len, 4);
    q_probe("q_tail_kept", 2, 4, 1);

    // Reverse request ignored, then turn up.
    do_reset();
    prey_vld = 1'b0;
    set_dir(3);
    set_dir(0);
    do_tick(1, ec);
    check("up_headx", headx, 4);
    check("up_heady", heady, 3);

    // Run into the top wall.
    for (int k = 0; k < 3; k++) do_tick(1, ec);
    check("top_heady", heady, 0);
    do_tick(1, ec);
    check("wall_go", game_over, 1);
    check("wall_heady", heady, 0);
    set_dir(1);
    do_tick(1, ec);
    check("dead_headx", headx, 4);
    q_probe("q_dead", 4, 0, 1);

    // Grow to 5 and loop into own body.
    do_reset();
    check("rst_clears_go", game_over, 0);
    preyx = 5'd5; preyy = 5'd4; prey_vld = 1'b1;
    do_tick(1, ec);
    preyx = 5'd6;
    do_tick(1, ec);
    check("grow_len", len, 5);
    prey_vld = 1'b0;
    set_dir(2); do_tick(1, ec);
    set_dir(3); do_tick(1, ec);
    set_dir(0); do_tick(1, ec);
    check("self_hit_go", game_over, 1);

    // Length 4 chasing its own tail survives.
    do_reset();
    preyx = 5'd5; preyy = 5'd4; prey_vld = 1'b1;
    do_tick(1, ec);
    prey_vld = 1'b0;
    set_dir(2); do_tick(1, ec);
    set_dir(3); do_tick(1, ec);
    set_dir(0); do_tick(1, ec);
    set_dir(1); do_tick(1, ec);
    check("chase_go", game_over, 0);
    check("chase_headx", headx, 5);
    check("chase_heady", heady, 4);

    // Reset landing in the middle of SCAN.
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("midscan_headx", headx, 4);
    check("midscan_len", len, 3);
    repeat (4) @(posedge clk);
    #1;
    check("midscan_idle_headx", headx, 4);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
